// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the main memory model: FSM states, line geometry,
// and the constant functions used to size lanes from the bus width.
package main_mem_pkg;

    localparam int unsigned LINE_BITS  = 128;
    localparam int unsigned LINE_BYTES = LINE_BITS / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RESP,
        ST_ERR
    } state_e;

    // Number of bus-width lanes that make up one 128-bit line
    function automatic int unsigned lane_count(input int unsigned dwidth);
        return LINE_BITS / dwidth;
    endfunction

    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= value) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/main_mem_pipe_if.sv
// Wishbone slave bundle for main_mem_pipe; i_* driven by the master, o_* by the memory.
interface main_mem_pipe_if #(
    parameter int unsigned WB_DWIDTH = 32,
    parameter int unsigned WB_SWIDTH = WB_DWIDTH / 8
);
    logic [31:0]          i_wb_adr;
    logic [WB_SWIDTH-1:0] i_wb_sel;
    logic                 i_wb_we;
    logic [WB_DWIDTH-1:0] i_wb_dat;
    logic                 i_wb_cyc;
    logic                 i_wb_stb;
    logic [WB_DWIDTH-1:0] o_wb_dat;
    logic                 o_wb_ack;
    logic                 o_wb_err;

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/main_mem_lane_mux.sv
// Combinational lane access into a 128-bit line: byte-masked write merge of one
// bus-width lane, and extraction of the addressed lane for reads.
module main_mem_lane_mux
    import main_mem_pkg::*;
#(
    parameter int unsigned WB_DWIDTH = 32,
    parameter int unsigned WB_SWIDTH = WB_DWIDTH / 8
) (
    input  logic [LINE_BITS-1:0] line,
    input  logic [1:0]           lane,
    input  logic [WB_SWIDTH-1:0] sel,
    input  logic [WB_DWIDTH-1:0] wdat,
    output logic [LINE_BITS-1:0] wr_line_c,
    output logic [WB_DWIDTH-1:0] rd_dat_c
);
    localparam int unsigned LANES = lane_count(WB_DWIDTH);

    always_comb begin
        wr_line_c = line;
        rd_dat_c  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (32'(lane) == l) begin
                rd_dat_c = line[l*WB_DWIDTH +: WB_DWIDTH];
                for (int unsigned b = 0; b < WB_SWIDTH; b++) begin
                    if (sel[b]) wr_line_c[l*WB_DWIDTH + b*8 +: 8] = wdat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/main_mem_pipe.sv
// Wishbone main-memory model: 128-bit line RAM with selectable bus width,
// programmable read latency, address wrap mode and out-of-range error response.
module main_mem_pipe
    import main_mem_pkg::*;
#(
    parameter int unsigned WB_DWIDTH  = 32,
    parameter int unsigned WB_SWIDTH  = WB_DWIDTH / 8,
    parameter int unsigned MEM_AW     = 27,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WRAP_AW    = 25
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_mem_ctrl,
    main_mem_pipe_if.slave wb
);
    localparam int unsigned LANE_LSB  = log2(WB_DWIDTH / 8);
    localparam int unsigned LINE_AW   = MEM_AW - 4;
    localparam int unsigned LINES     = 2 ** LINE_AW;
    localparam int unsigned CNT_W     = 4;
    localparam logic [31:0] WRAP_MASK = 32'((64'd1 << WRAP_AW) - 64'd1);
    localparam logic [31:0] HIGH_MASK = ~32'((64'd1 << MEM_AW) - 64'd1);

    state_e               state_q, state_d;
    logic [LINE_AW-1:0]   line_q, line_d;
    logic [1:0]           lane_q, lane_d;
    logic [WB_SWIDTH-1:0] sel_q, sel_d;
    logic [WB_DWIDTH-1:0] wdat_q, wdat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [WB_DWIDTH-1:0] dat_q, dat_d;
    logic [LINE_BITS-1:0] mem_q [LINES];

    logic [MEM_AW-1:0]    eff_adr_c;
    logic                 range_err_c;
    logic [LINE_AW-1:0]   adr_line_c, line_sel_c;
    logic [1:0]           adr_lane_c, lane_sel_c;
    logic [LINE_BITS-1:0] rd_line_c, wr_line_c;
    logic [WB_DWIDTH-1:0] rd_dat_c;
    logic                 mem_we_c;

    // Address decode; in IDLE the live bus address feeds the array so a
    // single-cycle read can capture on the acceptance edge.
    always_comb begin
        eff_adr_c   = i_mem_ctrl ? MEM_AW'(wb.i_wb_adr & WRAP_MASK) : wb.i_wb_adr[MEM_AW-1:0];
        range_err_c = !i_mem_ctrl && ((wb.i_wb_adr & HIGH_MASK) != 32'd0);
        adr_line_c  = eff_adr_c[MEM_AW-1:4];
        adr_lane_c  = 2'(eff_adr_c[3:0] >> LANE_LSB);
        line_sel_c  = (state_q == ST_IDLE) ? adr_line_c : line_q;
        lane_sel_c  = (state_q == ST_IDLE) ? adr_lane_c : lane_q;
        rd_line_c   = mem_q[line_sel_c];
    end

    main_mem_lane_mux #(
        .WB_DWIDTH (WB_DWIDTH),
        .WB_SWIDTH (WB_SWIDTH)
    ) u_lane_mux (
        .line      (rd_line_c),
        .lane      (lane_sel_c),
        .sel       (sel_q),
        .wdat      (wdat_q),
        .wr_line_c (wr_line_c),
        .rd_dat_c  (rd_dat_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        lane_d   = lane_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        mem_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb.i_wb_cyc && wb.i_wb_stb) begin
                    line_d = adr_line_c;
                    lane_d = adr_lane_c;
                    sel_d  = wb.i_wb_sel;
                    wdat_d = wb.i_wb_dat;
                    cnt_d  = CNT_W'(RD_LATENCY - 1);
                    if (range_err_c) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (wb.i_wb_we) begin
                        state_d = ST_WRITE;
                        ack_d   = 1'b1;
                    end else if (RD_LATENCY == 1) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        dat_d   = rd_dat_c;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                mem_we_c = !i_rst;
                state_d  = ST_IDLE;
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    dat_d   = rd_dat_c;
                    ack_d   = wb.i_wb_stb && wb.i_wb_cyc;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            lane_q  <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            lane_q  <= lane_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we_c) mem_q[line_q] <= wr_line_c;
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_err = err_q;
    assign wb.o_wb_dat = dat_q;

endmodule
